// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between the instruction cache and the data
//   cache. One requester is granted per cycle and its command is forwarded
//   combinationally. Each accepted load tag is tagged with its owner, so the
//   returning completion tag is routed only to the cache that issued the load.
//
// Ports
//   clock, reset                  system clock, synchronous active-high reset
//   icache2mem_command/addr       icache request (loads only)
//   dcache2mem_command/addr/data  dcache request (loads and stores)
//   mem2proc_response             memory accept tag, 0 = rejected
//   mem2proc_data/tag             completion data and tag, tag 0 = none
//   proc2mem_command/addr/data    forwarded request of the granted cache
//   mem2{i,d}cache_response       accept tag for the granted cache, else 0
//   mem2{i,d}cache_response_valid high when that cache was granted this cycle
//   mem2{i,d}cache_tag            completion tag when owned by that cache
//   mem2{i,d}cache_data           completion data, passed through
//   outstanding_cnt               number of valid owner entries
//   stray_tag                     nonzero completion tag with no owner
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      icache2mem_command,
    input  logic [XLEN-1:0] icache2mem_addr,
    input  logic [1:0]      dcache2mem_command,
    input  logic [XLEN-1:0] dcache2mem_addr,
    input  logic [63:0]     dcache2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2icache_response,
    output logic [3:0]      mem2dcache_response,
    output logic            mem2icache_response_valid,
    output logic            mem2dcache_response_valid,
    output logic [3:0]      mem2icache_tag,
    output logic [3:0]      mem2dcache_tag,
    output logic [63:0]     mem2icache_data,
    output logic [63:0]     mem2dcache_data,
    output logic [4:0]      outstanding_cnt,
    output logic            stray_tag
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {GRANT_NONE, GRANT_I, GRANT_D} grant_e;

    grant_e           grant;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             icache_req;
    logic             dcache_req;
    logic             accepted;
    logic             alloc;
    logic             completion_hit;

    // Bit 0 exists only so a raw 4-bit tag can index the table; it is never set.
    logic [15:0]      owner_valid;
    logic [15:0]      owner_is_d;
    logic [15:0]      owner_valid_next;
    logic [15:0]      owner_is_d_next;
    logic [4:0]       cnt_next;

    assign icache_req = (icache2mem_command != BUS_NONE);
    assign dcache_req = (dcache2mem_command != BUS_NONE);
    assign starved    = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign accepted   = (mem2proc_response != 4'd0);

    // Dcache wins by default; a starved icache takes the port.
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant = GRANT_NONE;
        if (icache_req && (!dcache_req || starved)) begin
            grant = GRANT_I;
        end else if (dcache_req) begin
            grant = GRANT_D;
        end
    end

    always_comb begin
        proc2mem_command          = BUS_NONE;
        proc2mem_addr             = '0;
        proc2mem_data             = '0;
        mem2icache_response       = 4'd0;
        mem2dcache_response       = 4'd0;
        mem2icache_response_valid = 1'b0;
        mem2dcache_response_valid = 1'b0;
        case (grant)
            GRANT_I: begin
                proc2mem_command          = icache2mem_command;
                proc2mem_addr             = icache2mem_addr;
                mem2icache_response       = mem2proc_response;
                mem2icache_response_valid = 1'b1;
            end
            GRANT_D: begin
                proc2mem_command          = dcache2mem_command;
                proc2mem_addr             = dcache2mem_addr;
                proc2mem_data             = dcache2mem_data;
                mem2dcache_response       = mem2proc_response;
                mem2dcache_response_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Completion routing: only a tag with a live owner entry reaches a cache.
    assign completion_hit  = (mem2proc_tag != 4'd0) && owner_valid[mem2proc_tag];
    assign stray_tag       = (mem2proc_tag != 4'd0) && !owner_valid[mem2proc_tag];
    assign mem2icache_tag  = (completion_hit && !owner_is_d[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    assign mem2dcache_tag  = (completion_hit &&  owner_is_d[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    assign mem2icache_data = mem2proc_data;
    assign mem2dcache_data = mem2proc_data;

    assign alloc = (grant != GRANT_NONE) && (proc2mem_command == BUS_LOAD) && accepted;

    // Clear before allocate: a tag that completes and is reissued in the same
    // cycle ends up owned by the new requester.
    always_comb begin
        owner_valid_next = owner_valid;
        owner_is_d_next  = owner_is_d;
        if (completion_hit) begin
            owner_valid_next[mem2proc_tag] = 1'b0;
        end
        if (alloc) begin
            owner_valid_next[mem2proc_response] = 1'b1;
            owner_is_d_next[mem2proc_response]  = (grant == GRANT_D);
        end
    end

    always_comb begin
        cnt_next = 5'd0;
        for (int i = 1; i < 16; i++) begin
            cnt_next = cnt_next + 5'(owner_valid_next[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_valid     <= '0;
            starve_cnt      <= '0;
            outstanding_cnt <= 5'd0;
        end else begin
            owner_valid     <= owner_valid_next;
            outstanding_cnt <= cnt_next;
            if (!icache_req || ((grant == GRANT_I) && accepted)) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: owner_is_d is only meaningful under a set valid bit, so this table needs no reset.
    always_ff @(posedge clock) begin
        owner_is_d <= owner_is_d_next;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (command/address/data, 4-bit response tag, 4-bit completion tag) between the instruction cache and the data cache.
- Picks one requester per cycle and forwards its command combinationally. Records which requester owns each accepted load tag, then routes the returning data and tag only to that owner.
- Sits between icache/dcache and the memory model. Each cache sees a private memory interface with the same protocol as the bare memory port.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the icache may be denied or rejected before it takes priority.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- icache2mem_command  in  2  BUS_NONE=0, BUS_LOAD=1 (icache issues loads only)
- icache2mem_addr  in  XLEN  8-byte-aligned fetch address
- dcache2mem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE=2
- dcache2mem_addr  in  XLEN  dcache address
- dcache2mem_data  in  64  store data
- mem2proc_response  in  4  memory accept tag; 0 = rejected
- mem2proc_data  in  64  completion data
- mem2proc_tag  in  4  completion tag; 0 = none
- proc2mem_command  out  2  forwarded command
- proc2mem_addr  out  XLEN  forwarded address
- proc2mem_data  out  64  forwarded store data
- mem2icache_response, mem2dcache_response  out  4  accept tag to the granted requester, else 0
- mem2icache_response_valid, mem2dcache_response_valid  out  1  high when that requester was granted this cycle
- mem2icache_tag, mem2dcache_tag  out  4  completion tag if owned by that requester, else 0
- mem2icache_data, mem2dcache_data  out  64  mem2proc_data passed through unconditionally
- outstanding_cnt  out  5  number of valid owner entries
- stray_tag  out  1  one-cycle pulse: nonzero completion tag with no owner

Behaviour:
- State:
  - owner_valid[15:1] and owner_is_d[15:1]; tag 0 has no entry.
  - starve_cnt (CNT_W bits).
- Arbitration (combinational, same cycle):
  - Default priority is dcache.
  - If starve_cnt == STARVE_LIMIT and the icache is requesting, the icache wins.
  - Only a requester with command != BUS_NONE is eligible.
  - The granted requester's command/addr/data drive proc2mem_*.
  - With no grant, proc2mem_command = BUS_NONE and proc2mem_addr/data = 0.
- Accept response:
  - The granted requester's *_response = mem2proc_response and its *_response_valid = 1.
  - The other requester gets response 0 and valid 0, so it retries next cycle.
- Allocation: a granted BUS_LOAD with mem2proc_response != 0 sets owner_valid[resp] = 1 and owner_is_d[resp] = (grant == dcache) at the next edge. BUS_STORE never allocates.
- Completion (combinational routing, clear at the next edge):
  - When mem2proc_tag != 0 and owner_valid[tag] is set, drive the tag to the owner's *_tag output and 0 to the other's, and clear the entry.
  - When the entry is not valid, both *_tag outputs are 0 and stray_tag = 1.
- Same-cycle completion and allocation on the same tag: the clear is applied first, then the allocation; the entry ends valid with the new owner.
- Starvation counter:
  - Reset to 0 whenever the icache is granted and accepted, or the icache is idle.
  - Otherwise increments (saturating at STARVE_LIMIT) each cycle the icache requests without being accepted.
- outstanding_cnt is the registered popcount of owner_valid, so it reflects the table after the edge.
- Reset:
  - All owner entries invalid, starve_cnt = 0, outstanding_cnt = 0.
  - Combinational outputs follow their rules.
  - Completions arriving after reset for tags allocated before reset are stray: dropped with stray_tag = 1.

Test Plan:
- Icache only, command LOAD at addr 0x100, response 3; tag 3 returns 5 cycles later with data 0xDEADBEEF_00000013 -> mem2icache_response = 3 with valid = 1; on completion mem2icache_tag = 3, mem2dcache_tag = 0; outstanding_cnt goes 0→1→0.
- Both request LOAD in the same cycle, response 5 -> dcache granted: proc2mem_addr = dcache addr, mem2dcache_response = 5, mem2icache_response = 0; tag 5 later routes to the dcache only.
- Dcache requests continuously, icache requests continuously, memory always accepts -> icache is granted exactly once every STARVE_LIMIT+1 = 5 cycles.
- Dcache STORE accepted with response 7, then memory returns tag 7 -> no allocation; stray_tag = 1; both *_tag outputs = 0.
- Tag 2 owned by the icache completes in the same cycle the dcache gets a load accepted with response 2 -> the icache sees tag 2; the next cycle entry 2 is valid with owner dcache; outstanding_cnt unchanged.
- Three loads outstanding, then reset asserted for 1 cycle, then memory returns those tags -> outstanding_cnt = 0 after reset; each return pulses stray_tag; the caches see tag 0.
